// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the fetch stage and IF/ID pipeline register:
// RV32 opcode constants, the bubble encoding and the register-index width.
package if_id_stage_pkg;

  localparam int unsigned REG_IDX_W = 5;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // addi x0,x0,0 -- the canonical bubble
  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

  // True when the opcode reads a second source register (rs2).
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use hazard detector: compares the source registers of the instruction
// held in IF/ID against the destination of a load sitting in EX.
// Purely combinational.
module hazard_detect
  import if_id_stage_pkg::*;
(
  input  logic                 i_valid,
  input  logic [31:0]          i_inst,
  input  logic                 i_idex_memread,
  input  logic [REG_IDX_W-1:0] i_idex_rd,
  output logic                 o_stall
);

  logic [REG_IDX_W-1:0] w_rs1;
  logic [REG_IDX_W-1:0] w_rs2;
  logic                 w_uses_rs2;

  assign w_rs1      = i_inst[19:15];
  assign w_rs2      = i_inst[24:20];
  assign w_uses_rs2 = uses_rs2(i_inst[6:0]);

  // Stall when a load in EX writes a non-zero register this instruction reads
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    o_stall = 1'b0;
    if (i_valid && i_idex_memread && (i_idex_rd != '0)) begin
      o_stall = (i_idex_rd == w_rs1) || (w_uses_rs2 && (i_idex_rd == w_rs2));
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register of the five-stage RV32 core.
// Owns the PC, drives the instruction-memory address, latches the fetched
// instruction with its PC, and produces load-use stall and branch flush.
// Optional feature macro: IF_ID_PERF_EN enables saturating stall/flush
// counters; without it stall_cnt_o and flush_cnt_o are tied to zero.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_ENC
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic [31:0]          imem_addr_o,
  input  logic [31:0]          imem_inst_i,
  input  logic                 branch_taken_i,
  input  logic [31:0]          branch_target_i,
  input  logic                 idex_memread_i,
  input  logic [REG_IDX_W-1:0] idex_rd_i,
  output logic [31:0]          inst_o,
  output logic [31:0]          pc_o,
  output logic                 valid_o,
  output logic                 stall_o,
  output logic                 flush_o,
  output logic [31:0]          stall_cnt_o,
  output logic [31:0]          flush_cnt_o
);

  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_ifid_pc;
  logic        r_valid;

  logic        w_stall;
  logic        w_flush;

  hazard_detect u_hazard_detect (
    .i_valid        (r_valid),
    .i_inst         (r_inst),
    .i_idex_memread (idex_memread_i),
    .i_idex_rd      (idex_rd_i),
    .o_stall        (w_stall)
  );

  // A stall recomputes the branch compare next cycle, so it masks the redirect
  assign w_flush = r_valid & branch_taken_i & ~w_stall;

  assign imem_addr_o = r_pc;
  assign inst_o      = r_inst;
  assign pc_o        = r_ifid_pc;
  assign valid_o     = r_valid;
  assign stall_o     = w_stall;
  assign flush_o     = w_flush;

  // PC and IF/ID update: idle, stall, redirect, or normal fetch (in priority order)
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      r_pc      <= RESET_PC;
      r_inst    <= NOP_INST;
      r_ifid_pc <= '0;
      r_valid   <= 1'b0;
    end else if (!start_i) begin
      r_inst    <= NOP_INST;
      r_ifid_pc <= '0;
      r_valid   <= 1'b0;
    end else if (w_stall) begin
      r_pc      <= r_pc;
    end else if (w_flush) begin
      r_pc      <= branch_target_i;
      r_inst    <= NOP_INST;
      r_ifid_pc <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_pc      <= r_pc + 32'd4;
      r_inst    <= imem_inst_i;
      r_ifid_pc <= r_pc;
      r_valid   <= 1'b1;
    end
  end

`ifdef IF_ID_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating event counters for stall and flush cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage. Expected values are
// hand-computed from the fetch/IF-ID behaviour; the imem model is a single
// driven word set before each fetch edge.
module tb_if_id_stage;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        idex_memread;
  logic [4:0]  idex_rd;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        valid;
  logic        stall;
  logic        flush;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADD  = 32'h0020_81B3; // add  x3,x1,x2
  localparam logic [31:0] ADDI = 32'h0011_0293; // addi x5,x2,1
  localparam logic [31:0] BEQ0 = 32'h0000_0063; // beq  x0,x0,0
  localparam logic [31:0] BEQ  = 32'h0020_8463; // beq  x1,x2,8

  if_id_stage dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .imem_addr_o     (imem_addr),
    .imem_inst_i     (imem_inst),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .idex_memread_i  (idex_memread),
    .idex_rd_i       (idex_rd),
    .inst_o          (inst),
    .pc_o            (pc),
    .valid_o         (valid),
    .stall_o         (stall),
    .flush_o         (flush),
    .stall_cnt_o     (stall_cnt),
    .flush_cnt_o     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".addr"},  imem_addr, 32'h0);
    check({tag, ".inst"},  inst,      NOP);
    check({tag, ".pc"},    pc,        32'h0);
    check({tag, ".valid"}, {31'b0, valid}, 32'd0);
    check({tag, ".stall"}, {31'b0, stall}, 32'd0);
    check({tag, ".flush"}, {31'b0, flush}, 32'd0);
    check({tag, ".scnt"},  stall_cnt, 32'h0);
    check({tag, ".fcnt"},  flush_cnt, 32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; imem_inst = NOP;
    branch_taken = 1'b0; branch_target = '0;
    idex_memread = 1'b0; idex_rd = '0;

    // Reset state
    #12;
    check_reset_state("rst");

    // Reset and run: addresses 0,4,8 with pc_o one fetch behind
    rst = 1'b0; start = 1'b1;
    tick();
    check("run1.addr",  imem_addr, 32'h4);
    check("run1.pc",    pc,        32'h0);
    check("run1.valid", {31'b0, valid}, 32'd1);
    check("run1.inst",  inst,      NOP);
    tick();
    check("run2.addr",  imem_addr, 32'h8);
    check("run2.pc",    pc,        32'h4);

    // Load-use: add x3,x1,x2 at PC 8
    imem_inst = ADD;
    tick();
    check("add.inst", inst, ADD);
    check("add.pc",   pc,   32'h8);
    idex_memread = 1'b1; idex_rd = 5'd0; #1;
    check("x0.stall",  {31'b0, stall}, 32'd0);
    idex_rd = 5'd2; #1;
    check("rs2.stall", {31'b0, stall}, 32'd1);
    idex_memread = 1'b0; #1;
    check("nomem.stall", {31'b0, stall}, 32'd0);
    idex_memread = 1'b1; idex_rd = 5'd1; #1;
    check("rs1.stall", {31'b0, stall}, 32'd1);
    tick();
    check("held.addr", imem_addr, 32'hC);
    check("held.inst", inst,      ADD);
    check("held.pc",   pc,        32'h8);
    idex_memread = 1'b0; #1;
    check("resume.stall", {31'b0, stall}, 32'd0);

    // addi x5,x2,1 at PC 12: inst[24:20]=1 must not stall
    imem_inst = ADDI;
    tick();
    check("addi.inst", inst, ADDI);
    check("addi.addr", imem_addr, 32'h10);
    idex_memread = 1'b1; idex_rd = 5'd1; #1;
    check("addi.rs2.stall", {31'b0, stall}, 32'd0);
    idex_rd = 5'd2; #1;
    check("addi.rs1.stall", {31'b0, stall}, 32'd1);
    idex_memread = 1'b0;

    // Taken branch with IF/ID PC = 0x10
    imem_inst = BEQ0;
    tick();
    check("br.pc", pc, 32'h10);
    branch_taken = 1'b1; branch_target = 32'h40; #1;
    check("br.flush", {31'b0, flush}, 32'd1);
    check("br.stall", {31'b0, stall}, 32'd0);
    tick();
    check("br.addr",  imem_addr, 32'h40);
    check("br.inst",  inst,      NOP);
    check("br.valid", {31'b0, valid}, 32'd0);
    check("br.bpc",   pc,        32'h0);
    check("br.flush2", {31'b0, flush}, 32'd0);
    branch_taken = 1'b0;

    // Stall vs. branch: beq x1,x2,8 at PC 0x40, load writes x2
    imem_inst = BEQ;
    tick();
    check("sb.inst", inst, BEQ);
    idex_memread = 1'b1; idex_rd = 5'd2;
    branch_taken = 1'b1; branch_target = 32'h80; #1;
    check("sb.stall", {31'b0, stall}, 32'd1);
    check("sb.flush", {31'b0, flush}, 32'd0);
    tick();
    check("sb.addr", imem_addr, 32'h44);
    check("sb.inst2", inst, BEQ);
`ifdef IF_ID_PERF_EN
    // one stall from the add hazard, one here; one flush from the 0x10 branch
    check("sb.scnt", stall_cnt, 32'd2);
    check("sb.fcnt", flush_cnt, 32'd1);
`else
    check("sb.scnt", stall_cnt, 32'd0);
    check("sb.fcnt", flush_cnt, 32'd0);
`endif

    // Reset mid-stall: asynchronous, visible before the next edge
    #2;
    check("pre.stall", {31'b0, stall}, 32'd1);
    rst = 1'b1; #1;
    check_reset_state("arst");
    idex_memread = 1'b0; branch_taken = 1'b0; idex_rd = '0;
    #1; rst = 1'b0;
    imem_inst = BEQ0;
    tick();
    check("rel.addr",  imem_addr, 32'h4);
    check("rel.pc",    pc,        32'h0);
    check("rel.valid", {31'b0, valid}, 32'd1);

    // PC wrap: redirect to 0xFFFF_FFFC then fetch wraps to 0
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    check("wrap.tgt", imem_addr, 32'hFFFF_FFFC);
    branch_taken = 1'b0; imem_inst = NOP;
    tick();
    check("wrap.addr", imem_addr, 32'h0);
    check("wrap.pc",   pc,        32'hFFFF_FFFC);

    // start_i low: PC frozen, bubble fed
    start = 1'b0;
    tick();
    check("idle.addr",  imem_addr, 32'h0);
    check("idle.valid", {31'b0, valid}, 32'd0);
    check("idle.inst",  inst, NOP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
